assert_result_collector: RTL and testbench

ASSERT_RESULT_COLLECTOR -- requirements
Module: assert_result_collector

---
 rtl/assert_result_collector.sv | 106 ++++++++++
 tb/tb_assert_result_collector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/assert_result_collector.sv
// assert_result_collector: gathers pass/fail pulses from assertion checkers into
// per-channel saturating counters, a timestamped failure-event FIFO and sticky flags.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   chk_en/chk_pass/chk_fail per-channel enable mask and one-cycle result pulses
//   clear                    sync clear of counters, flags and FIFO (timestamp kept)
//   rd_sel -> rd_pass_cnt/rd_fail_cnt   registered counter readout
//   evt_valid/evt_ready/evt_mask/evt_time  first-word-fall-through event FIFO
//   any_fail/first_idx/ovf/irq          sticky status and interrupt
module assert_result_collector #(
  parameter int NUM_CHK = 8,
  parameter int CNT_W   = 16,
  parameter int LOG_AW  = 4,
  localparam int SW     = NUM_CHK > 1 ? $clog2(NUM_CHK) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CHK-1:0] chk_en,
  input  logic [NUM_CHK-1:0] chk_pass,
  input  logic [NUM_CHK-1:0] chk_fail,
  input  logic               clear,
  input  logic [SW-1:0]      rd_sel,
  output logic [CNT_W-1:0]   rd_pass_cnt,
  output logic [CNT_W-1:0]   rd_fail_cnt,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [NUM_CHK-1:0] evt_mask,
  output logic [CNT_W-1:0]   evt_time,
  output logic               any_fail,
  output logic [SW-1:0]      first_idx,
  output logic               ovf,
  output logic               irq
);
  // Counter arrays are padded to a power of two so any rd_sel value indexes a real entry.
  localparam int NP    = 2 ** SW;
  localparam int DEPTH = 2 ** LOG_AW;
  logic [NP-1:0]      f, p;
  logic [CNT_W-1:0]   ts;
  logic [CNT_W-1:0]   pass_cnt [NP];
  logic [CNT_W-1:0]   fail_cnt [NP];
  logic [NUM_CHK-1:0] mask_mem [DEPTH];
  logic [CNT_W-1:0]   time_mem [DEPTH];
  logic [LOG_AW:0]    wr_ptr, rd_ptr;
  logic               empty, full, pop, push, accept, any_nxt, ovf_nxt;
  logic [SW-1:0]      lo;
  // Fail wins over pass when both pulse on the same channel.
  assign f = NP'(chk_fail & chk_en);
  assign p = NP'(chk_pass & chk_en & ~chk_fail);
  always_comb begin
    empty   = wr_ptr == rd_ptr;
    full    = (wr_ptr - rd_ptr) == (LOG_AW+1)'(DEPTH);
    pop     = !empty && evt_ready && !clear;
    push    = |f && !clear;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    accept  = push && (!full || pop);
    any_nxt = !clear && (any_fail || |f);
    ovf_nxt = !clear && (ovf || (push && !accept));
    lo = '0;
    for (int i = NP - 1; i >= 0; i--)
      if (f[i]) lo = SW'(i);
  end
  // Head outputs read zero while empty so they match the reset values.
  assign evt_valid = !empty;
  assign evt_mask  = empty ? '0 : mask_mem[rd_ptr[LOG_AW-1:0]];
  assign evt_time  = empty ? '0 : time_mem[rd_ptr[LOG_AW-1:0]];
  always_ff @(posedge clk)
    if (accept) begin
      mask_mem[wr_ptr[LOG_AW-1:0]] <= f[NUM_CHK-1:0];
      time_mem[wr_ptr[LOG_AW-1:0]] <= ts;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_pass_cnt <= '0;
      rd_fail_cnt <= '0;
      any_fail    <= 1'b0;
      first_idx   <= '0;
      ovf         <= 1'b0;
      irq         <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        pass_cnt[i] <= '0;
        fail_cnt[i] <= '0;
      end
    end else begin
      ts          <= ts + 1'b1;
      wr_ptr      <= clear ? '0 : wr_ptr + (LOG_AW+1)'(accept);
      rd_ptr      <= clear ? '0 : rd_ptr + (LOG_AW+1)'(pop);
      rd_pass_cnt <= pass_cnt[rd_sel];
      rd_fail_cnt <= fail_cnt[rd_sel];
      any_fail    <= any_nxt;
      ovf         <= ovf_nxt;
      irq         <= any_nxt | ovf_nxt;
      if (clear) first_idx <= '0;
      else if (!any_fail && |f) first_idx <= lo;
      for (int i = 0; i < NP; i++)
        if (clear) begin
          pass_cnt[i] <= '0;
          fail_cnt[i] <= '0;
        end else begin
          if (p[i] && pass_cnt[i] != '1) pass_cnt[i] <= pass_cnt[i] + 1'b1;
          if (f[i] && fail_cnt[i] != '1) fail_cnt[i] <= fail_cnt[i] + 1'b1;
        end
    end
endmodule

// File: tb/tb_assert_result_collector.sv
// tb_assert_result_collector: directed and random checks of assert_result_collector against a queue-based model.
module tb_assert_result_collector;
  logic        clk = 0, rst_n = 1;
  logic [7:0]  chk_en = 0, chk_pass = 0, chk_fail = 0;
  logic        clear = 0, evt_ready = 0;
  logic [2:0]  rd_sel = 0;
  logic [15:0] rd_pass_cnt, rd_fail_cnt, evt_time;
  logic [7:0]  evt_mask;
  logic        evt_valid, any_fail, ovf, irq;
  logic [2:0]  first_idx;
  logic [3:0]  rd_pass_s, rd_fail_s, evt_time_s;
  logic [7:0]  evt_mask_s;
  logic        evt_valid_s, any_fail_s, ovf_s, irq_s;
  logic [2:0]  first_idx_s;
  int n_cmp = 0, n_err = 0;
  int unsigned pc [8], fc [8];
  logic [15:0] ts_m, rdp_m, rdf_m, last;
  logic [3:0]  rdp4_m, rdf4_m;
  logic [7:0]  qm [$];
  logic [15:0] qt [$];
  bit          any_m, ovf_m, irq_m;
  logic [2:0]  fi_m;
  assert_result_collector #(.NUM_CHK(8), .CNT_W(16), .LOG_AW(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .chk_pass(chk_pass), .chk_fail(chk_fail),
    .clear(clear), .rd_sel(rd_sel), .rd_pass_cnt(rd_pass_cnt), .rd_fail_cnt(rd_fail_cnt),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_mask(evt_mask), .evt_time(evt_time),
    .any_fail(any_fail), .first_idx(first_idx), .ovf(ovf), .irq(irq));
  assert_result_collector #(.NUM_CHK(8), .CNT_W(4), .LOG_AW(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .chk_pass(chk_pass), .chk_fail(chk_fail),
    .clear(clear), .rd_sel(rd_sel), .rd_pass_cnt(rd_pass_s), .rd_fail_cnt(rd_fail_s),
    .evt_valid(evt_valid_s), .evt_ready(evt_ready), .evt_mask(evt_mask_s), .evt_time(evt_time_s),
    .any_fail(any_fail_s), .first_idx(first_idx_s), .ovf(ovf_s), .irq(irq_s));
  always #5 clk = ~clk;
  function automatic int unsigned sat(int unsigned v, int unsigned m);
    return v > m ? m : v;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      pc[i] = 0;
      fc[i] = 0;
    end
    qm.delete();
    qt.delete();
    ts_m = 0; rdp_m = 0; rdf_m = 0; rdp4_m = 0; rdf4_m = 0;
    any_m = 0; ovf_m = 0; irq_m = 0; fi_m = 0;
  endtask
  // Behaviour of one clock edge, from the rules: counters, FIFO of {mask,time}, sticky flags.
  task automatic model_edge();
    logic [7:0] f, p;
    f = chk_fail & chk_en;
    p = chk_pass & chk_en & ~chk_fail;
    rdp_m  = 16'(sat(pc[rd_sel], 65535));
    rdf_m  = 16'(sat(fc[rd_sel], 65535));
    rdp4_m = 4'(sat(pc[rd_sel], 15));
    rdf4_m = 4'(sat(fc[rd_sel], 15));
    if (clear) begin
      for (int i = 0; i < 8; i++) begin
        pc[i] = 0;
        fc[i] = 0;
      end
      qm.delete();
      qt.delete();
      any_m = 0; ovf_m = 0; fi_m = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        pc[i] += p[i];
        fc[i] += f[i];
      end
      if (qm.size() > 0 && evt_ready) begin
        void'(qm.pop_front());
        void'(qt.pop_front());
      end
      if (f != 0) begin
        if (qm.size() < 16) begin
          qm.push_back(f);
          qt.push_back(ts_m);
        end else ovf_m = 1;
        if (!any_m) begin
          any_m = 1;
          for (int i = 0; i < 8; i++)
            if (f[i]) begin
              fi_m = 3'(i);
              break;
            end
        end
      end
    end
    irq_m = any_m | ovf_m;
    ts_m++;
  endtask
  task automatic check_all();
    chk("valid", evt_valid, qm.size() != 0);
    chk("mask", evt_mask, qm.size() != 0 ? qm[0] : 8'h0);
    chk("time", evt_time, qt.size() != 0 ? qt[0] : 16'h0);
    chk("any_fail", any_fail, any_m);
    chk("first_idx", first_idx, fi_m);
    chk("ovf", ovf, ovf_m);
    chk("irq", irq, irq_m);
    chk("rd_pass", rd_pass_cnt, rdp_m);
    chk("rd_fail", rd_fail_cnt, rdf_m);
    chk("rd_pass4", rd_pass_s, rdp4_m);
    chk("rd_fail4", rd_fail_s, rdf4_m);
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    chk_pass = 0;
    chk_fail = 0;
    clear = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    #1;
    do_reset();
    chk_en = 8'hFF;
    while (ts_m != 16'd10) step();
    chk_fail = 8'h04;
    step();
    chk("r34_valid", evt_valid, 1);
    chk("r34_mask", evt_mask, 8'h04);
    chk("r34_time", evt_time, 10);
    chk("r34_any", any_fail, 1);
    chk("r34_idx", first_idx, 2);
    chk("r34_irq", irq, 1);
    evt_ready = 1;
    step();
    evt_ready = 0;
    clear = 1;
    step();
    chk_en = 8'hF0;
    chk_fail = 8'h81;
    step();
    chk("r35_mask", evt_mask, 8'h80);
    chk("r35_idx", first_idx, 7);
    rd_sel = 0;
    step();
    chk("r35_cnt0", rd_fail_cnt, 0);
    rd_sel = 7;
    step();
    chk("r35_cnt7", rd_fail_cnt, 1);
    evt_ready = 1;
    step();
    chk("r35_single", evt_valid, 0);
    evt_ready = 0;
    clear = 1;
    step();
    chk_en = 8'hFF;
    repeat (17) begin
      chk_fail = 8'($urandom_range(1, 255));
      step();
    end
    chk("r36_ovf", ovf, 1);
    evt_ready = 1;
    last = 0;
    for (int k = 0; k < 16; k++) begin
      chk("r36_vld", evt_valid, 1);
      if (k > 0) chk("r36_inc", 32'(evt_time > last), 1);
      last = evt_time;
      step();
    end
    chk("r36_empty", evt_valid, 0);
    evt_ready = 0;
    clear = 1;
    step();
    rd_sel = 3;
    repeat (20) begin
      chk_pass = 8'h08;
      step();
    end
    step();
    chk("r37_sat", rd_pass_s, 4'hF);
    chk("r37_main", rd_pass_cnt, 20);
    rd_sel = 5;
    chk_pass = 8'h20;
    chk_fail = 8'h20;
    step();
    step();
    chk("r38_fail", rd_fail_cnt, 1);
    chk("r38_pass", rd_pass_cnt, 0);
    clear = 1;
    chk_fail = 8'h01;
    step();
    chk("r38_any", any_fail, 0);
    chk("r38_irq", irq, 0);
    chk("r38_ovf", ovf, 0);
    chk("r38_empty", evt_valid, 0);
    repeat (400) begin
      chk_en = 8'($urandom);
      chk_pass = 8'($urandom);
      chk_fail = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h0;
      evt_ready = $urandom_range(0, 2) == 0;
      rd_sel = 3'($urandom);
      clear = $urandom_range(0, 60) == 0;
      step();
    end
    chk_en = 8'hFF;
    evt_ready = 0;
    clear = 1;
    step();
    repeat (5) begin
      chk_fail = 8'($urandom_range(1, 255));
      step();
    end
    evt_ready = 1;
    step();
    #2;
    rst_n = 0;
    #1;
    chk("r39_valid", evt_valid, 0);
    model_reset();
    check_all();
    evt_ready = 0;
    @(negedge clk);
    rst_n = 1;
    chk_fail = 8'h10;
    step();
    chk("r39_time", evt_time, 0);
    chk("r39_mask", evt_mask, 8'h10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
